// File: rtl/pfpu32_pkg.sv
// Shared types and constants for the pfpu32 float-to-integer converter.
package pfpu32_pkg;

  typedef enum logic [1:0] {
    RM_NEAREST   = 2'd0,
    RM_ZERO      = 2'd1,
    RM_PLUS_INF  = 2'd2,
    RM_MINUS_INF = 2'd3
  } rmode_e;

  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] INT_MAX  = 32'h7FFFFFFF;
  localparam logic [31:0] INT_MIN  = 32'h80000000;

  // Stage-1 payload: classified operand plus the shift decision for stage 2.
  typedef struct packed {
    logic        sign;   // result sign (forced positive for NaN)
    logic        sat;    // saturate to INT_MAX/INT_MIN
    logic        inv;    // invalid flag when saturating
    logic        left;   // integer part wider than the mantissa: shift left
    logic        tiny;   // |value| < 0.5 or denormal: sticky only
    logic [4:0]  shamt;  // left shift 0..7 or right shift 1..24
    logic [23:0] mant;   // {hidden, fraction}
  } f2i_s1_t;

endpackage

// File: rtl/pfpu32_f2i_rnd.sv
// Combinational rounding of a truncated magnitude using guard/sticky bits.
module pfpu32_f2i_rnd
  import pfpu32_pkg::*;
(
  input  logic [23:0] mag_i,
  input  logic        guard_i,
  input  logic        sticky_i,
  input  logic        sign_i,
  input  logic [1:0]  rmode_i,
  output logic [24:0] mag_o,
  output logic        ine_o
);

  logic incr;

  // Decide whether the discarded fraction pushes the magnitude up by one
  always_comb begin
    incr = 1'b0;
    case (rmode_e'(rmode_i))
      RM_NEAREST:   incr = guard_i & (sticky_i | mag_i[0]);
      RM_PLUS_INF:  incr = ~sign_i & (guard_i | sticky_i);
      RM_MINUS_INF: incr = sign_i & (guard_i | sticky_i);
      default:      incr = 1'b0;
    endcase
    mag_o = {1'b0, mag_i} + {24'd0, incr};
    ine_o = guard_i | sticky_i;
  end

endmodule

// File: rtl/pfpu32_f2i.sv
// Two-stage single-precision float to signed 32-bit integer converter.
// Define PFPU32_F2I_ROUND_EN to honour rmode_i; otherwise every conversion
// truncates toward zero and no rounding-mode register is kept.
module pfpu32_f2i
  import pfpu32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        adv_i,
  input  logic        start_i,
  input  logic [31:0] opa_i,
  input  logic [1:0]  rmode_i,
  output logic        f2i_rdy_o,
  output logic [31:0] f2i_int_o,
  output logic        f2i_inv_o,
  output logic        f2i_ine_o
);

  // -2^31 is the one k=31 value that is representable exactly
  localparam logic [31:0] F_NEG_2P31 = 32'hCF000000;

  logic              op_nan;
  logic              op_sat;
  logic [7:0]        op_exp;
  logic [22:0]       op_frac;
  logic signed [9:0] op_k;

  f2i_s1_t    s1_d, s1_q;
  logic       s1_valid_d, s1_valid_q;
  logic [1:0] s2_rmode;

  // S1: unpack, classify and choose shift direction/amount
  always_comb begin
    op_exp  = opa_i[30:23];
    op_frac = opa_i[22:0];
    op_k    = $signed({2'b00, op_exp}) - $signed(10'(EXP_BIAS));
    op_nan  = (op_exp == 8'hFF) && (op_frac != 23'd0);
    op_sat  = (op_exp == 8'hFF) || (op_k >= 10'sd31);
    s1_d    = s1_q;
    if (adv_i) begin
      s1_d.sign  = opa_i[31] & ~op_nan;
      s1_d.sat   = op_sat;
      s1_d.inv   = op_sat & (opa_i != F_NEG_2P31);
      s1_d.left  = (op_k >= 10'sd23);
      s1_d.tiny  = (op_exp == 8'd0) || (op_k < -10'sd1);
      s1_d.mant  = {op_exp != 8'd0, op_frac};
      s1_d.shamt = 5'd0;
      if (op_k >= 10'sd23)
        s1_d.shamt = 5'(op_k - 10'sd23);
      else if (!s1_d.tiny)
        s1_d.shamt = 5'(10'sd23 - op_k);
    end
    s1_valid_d = flush_i ? 1'b0 : (adv_i ? start_i : s1_valid_q);
  end

  // S1 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

`ifdef PFPU32_F2I_ROUND_EN
  logic [1:0] rmode_d, rmode_q;

  // Carry the rounding mode alongside the stage-1 operand
  always_comb begin
    rmode_d = adv_i ? rmode_i : rmode_q;
  end

  // Rounding-mode register
  always_ff @(posedge clk) begin
    if (rst) rmode_q <= 2'd0;
    else     rmode_q <= rmode_d;
  end

  assign s2_rmode = rmode_q;
`else
  logic unused_rmode;
  assign unused_rmode = ^rmode_i;
  assign s2_rmode     = RM_ZERO;
`endif

  logic [47:0] rsh_ext;
  logic [23:0] rsh_mag;
  logic        rsh_guard, rsh_sticky;
  logic [24:0] rnd_mag;
  logic        rnd_ine;
  logic [31:0] mag, res;
  logic        rdy_d, rdy_q;
  logic [31:0] int_d, int_q;
  logic        inv_d, inv_q, ine_d, ine_q;

  // S2 right-shift: split mantissa into kept magnitude, guard and sticky
  always_comb begin
    rsh_ext = {s1_q.mant, 24'd0} >> s1_q.shamt;
    if (s1_q.tiny) begin
      rsh_mag    = 24'd0;
      rsh_guard  = 1'b0;
      rsh_sticky = |s1_q.mant;
    end else begin
      rsh_mag    = rsh_ext[47:24];
      rsh_guard  = rsh_ext[23];
      rsh_sticky = |rsh_ext[22:0];
    end
  end

  pfpu32_f2i_rnd u_rnd (
    .mag_i    (rsh_mag),
    .guard_i  (rsh_guard),
    .sticky_i (rsh_sticky),
    .sign_i   (s1_q.sign),
    .rmode_i  (s2_rmode),
    .mag_o    (rnd_mag),
    .ine_o    (rnd_ine)
  );

  // S2: select magnitude, negate, saturate and form flags
  always_comb begin
    mag   = s1_q.left ? ({8'd0, s1_q.mant} << s1_q.shamt) : {7'd0, rnd_mag};
    res   = s1_q.sign ? (~mag + 32'd1) : mag;
    int_d = int_q;
    inv_d = inv_q;
    ine_d = ine_q;
    if (adv_i) begin
      if (s1_q.sat) begin
        int_d = s1_q.sign ? INT_MIN : INT_MAX;
        inv_d = s1_q.inv;
        ine_d = 1'b0;
      end else begin
        int_d = res;
        inv_d = 1'b0;
        ine_d = ~s1_q.left & rnd_ine;
      end
    end
    rdy_d = flush_i ? 1'b0 : (adv_i ? s1_valid_q : rdy_q);
  end

  // S2 / output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= 1'b0;
      int_q <= 32'd0;
      inv_q <= 1'b0;
      ine_q <= 1'b0;
    end else begin
      rdy_q <= rdy_d;
      int_q <= int_d;
      inv_q <= inv_d;
      ine_q <= ine_d;
    end
  end

  assign f2i_rdy_o = rdy_q;
  assign f2i_int_o = int_q;
  assign f2i_inv_o = inv_q;
  assign f2i_ine_o = ine_q;

endmodule

// File: doc/pfpu32_f2i.md
PFPU32_F2I -- requirements
Module: pfpu32_f2i

Interface
REQ-001 Parameters: none; the block has a fixed 32-bit single-precision to 32-bit signed-integer datapath.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush_i  input  1  pipe flush; kills all in-flight conversions.
REQ-005 adv_i  input  1  pipe advance; when low all stage registers hold.
REQ-006 start_i  input  1  start conversion of opa_i; sampled only when adv_i=1.
REQ-007 opa_i  input  32  IEEE-754 single-precision operand.
REQ-008 rmode_i  input  2  rounding mode: 0=nearest-even, 1=toward zero, 2=toward +inf, 3=toward -inf.
REQ-009 f2i_rdy_o  output  1  result valid.
REQ-010 f2i_int_o  output  32  two's-complement integer result.
REQ-011 f2i_inv_o  output  1  invalid flag (NaN, infinity, out of range).
REQ-012 f2i_ine_o  output  1  inexact flag (discarded nonzero fraction).

Function
REQ-013 Two registered stages. S1 performs unpack, classify, shift-amount compute and latches rmode. S2 performs shift, round, negate, saturate and flags.
REQ-014 Latency: result on outputs exactly 2 adv_i=1 edges after the start_i edge; with continuous adv_i=1, one conversion is accepted per cycle.
REQ-015 Valid bits: s1 valid <= start_i on an adv edge; f2i_rdy_o <= s1 valid on an adv edge. Priority is rst > flush_i > adv_i.
REQ-016 flush_i=1 clears both valid bits the same edge; data registers are don't-care.
REQ-017 adv_i=0 holds every register, including f2i_rdy_o and the result/flags, unchanged.
REQ-018 k = exp-127.
  - exp=0 (zero/denormal): treated as |value|<1.
  - Zero: result 0, ine=0.
REQ-019 exp=255: result 0x7FFFFFFF with inv=1 for NaN and +inf; 0x80000000 with inv=1 for -inf.
REQ-020 Range:
  - k>=31: saturate, inv=1, ine=0 (+ -> 0x7FFFFFFF, - -> 0x80000000).
  - Exception: opa_i=0xCF000000 gives 0x80000000, inv=0.
REQ-021 23<=k<=30: magnitude = {1,frac} << (k-23); exact, ine=0.
REQ-022 k<23: magnitude = {1,frac} >> (23-k), with guard bit and sticky (OR of remaining bits) retained; exp=0 or k<-1 contributes sticky only.
REQ-023 Rounding increments magnitude when:
  - rmode 0: guard & (sticky | lsb).
  - rmode 2: positive & (guard|sticky).
  - rmode 3: negative & (guard|sticky).
  - rmode 1: never.
REQ-024 ine = guard|sticky. Rounded magnitude never exceeds 2^24 when k<23, so no overflow arises from rounding.
REQ-025 Negative results are the two's complement of the rounded magnitude; -0 yields 0x00000000.

Reset
REQ-026 On rst: f2i_rdy_o=0, s1 valid=0, f2i_int_o=0, f2i_inv_o=0, f2i_ine_o=0.
REQ-027 rst mid-conversion discards all in-flight operations; the first result after reset is from a start_i accepted after rst deasserts.

Configuration
REQ-028 Macro PFPU32_F2I_ROUND_EN.
  - Defined: rmode_i is honoured per REQ-023.
  - Undefined: rmode_i is ignored, all conversions truncate toward zero (rmode 1 behaviour), the rmode pipeline register is removed, and ine is still reported.

Structure
REQ-029 Shared package pfpu32_pkg holds:
  - rounding-mode enum (RM_NEAREST, RM_ZERO, RM_PLUS_INF, RM_MINUS_INF);
  - EXP_BIAS=127;
  - INT_MAX=0x7FFFFFFF;
  - INT_MIN=0x80000000.
REQ-030 One sub-module, pfpu32_f2i_rnd, is combinational (magnitude, guard, sticky, sign, rmode -> rounded magnitude, ine) and is instantiated in S2.

Verification
REQ-031 0x3FC00000 (1.5): rmode0 -> 0x00000002, ine=1; rmode1 -> 0x00000001, ine=1; without macro, rmode0 -> 0x00000001.
REQ-032 0x40200000 (2.5) rmode0 -> 0x00000002, ine=1. 0xBFC00000 (-1.5): rmode3 -> 0xFFFFFFFE; rmode2 -> 0xFFFFFFFF.
REQ-033 0x4F000000 -> 0x7FFFFFFF, inv=1. 0xCF000000 -> 0x80000000, inv=0. 0x7FC00000 -> 0x7FFFFFFF, inv=1. 0xFF800000 -> 0x80000000, inv=1.
REQ-034 0x4B800001 (16777218.0) -> 0x01000002, ine=0. 0x00000001 rmode2 -> 0x00000001, ine=1. 0x80000000 -> 0x00000000, ine=0.
REQ-035 Back-to-back starts on 3 cycles with adv=1: 3 results on consecutive cycles. adv=0 for 2 cycles mid-flight: outputs frozen, then resume.
REQ-036 flush_i while S1 valid: f2i_rdy_o stays 0 next edge. rst while rdy=1: rdy=0 and all outputs 0 the next edge.
